// File: rtl/pal_pkg.sv
// ---------------------------------------------------------------------------
// pal_pkg : size helpers, fuse-map index functions and config FSM states
//           for the programmable PAL.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int f_nl(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic int f_pt_bits(input int n_in, input int n_out);
    return 2 * f_nl(n_in, n_out);
  endfunction

  function automatic int f_mc_bits(input int n_in, input int n_out, input int n_pt);
    return n_pt * f_pt_bits(n_in, n_out) + 2;
  endfunction

  function automatic int f_fuse_bits(input int n_in, input int n_out, input int n_pt);
    return n_out * f_mc_bits(n_in, n_out, n_pt);
  endfunction

  function automatic int f_n_words(input int n_in, input int n_out, input int n_pt,
                                   input int cfg_w);
    return (f_fuse_bits(n_in, n_out, n_pt) + cfg_w - 1) / cfg_w;
  endfunction

  // True-literal fuse; the complement fuse sits at the next index.
  function automatic int f_lit_idx(input int o, input int t, input int l,
                                   input int n_in, input int n_out, input int n_pt);
    return o * f_mc_bits(n_in, n_out, n_pt) + t * f_pt_bits(n_in, n_out) + 2 * l;
  endfunction

  // reg_mode fuse; invert sits at the next index.
  function automatic int f_mode_idx(input int o, input int n_in, input int n_out,
                                    input int n_pt);
    return o * f_mc_bits(n_in, n_out, n_pt) + n_pt * f_pt_bits(n_in, n_out);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_pal_if.sv
// ---------------------------------------------------------------------------
// prog_pal_if : primary I/O and configuration-port bundle of the PAL.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prog_pal_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int CFG_W = 8
);
  logic [N_IN-1:0]  in_i;
  logic [N_OUT-1:0] out_o;
  logic             cfg_start;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_loaded;

  modport master (
    output in_i, cfg_start, cfg_valid, cfg_data,
    input  out_o, cfg_ready, cfg_busy, cfg_done, cfg_loaded
  );

  modport slave (
    input  in_i, cfg_start, cfg_valid, cfg_data,
    output out_o, cfg_ready, cfg_busy, cfg_done, cfg_loaded
  );
endinterface

`default_nettype wire

// File: rtl/pal_macrocell.sv
// ---------------------------------------------------------------------------
// pal_macrocell : OR of its product terms, optional inversion, feedback
//                 register and comb/registered output select.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pal_macrocell #(
  parameter int N_PT = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_clr,
  input  wire logic [N_PT-1:0] i_terms,
  input  wire logic            i_reg_mode,
  input  wire logic            i_invert,
  output logic                 o_out,
  output logic                 o_q
);

  logic w_f;
  logic r_q;

  assign w_f = (|i_terms) ^ i_invert;

  // q tracks f in both modes so feedback is always one cycle behind f.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_f;
    end
  end

  assign o_out = i_reg_mode ? r_q : w_f;
  assign o_q   = r_q;

endmodule

`default_nettype wire

// File: rtl/prog_pal.sv
// ---------------------------------------------------------------------------
// prog_pal : field-programmable sum-of-products array with word-serial
//            shadow loading and atomic commit of the fuse map.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_pal
  import pal_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int N_PT  = 4,
  parameter int CFG_W = 8
) (
  input  wire logic  clk,
  input  wire logic  rst,
  prog_pal_if.slave  bus
);

  localparam int NL        = f_nl(N_IN, N_OUT);
  localparam int PT_BITS   = f_pt_bits(N_IN, N_OUT);
  localparam int FUSE_BITS = f_fuse_bits(N_IN, N_OUT, N_PT);
  localparam int N_WORDS   = f_n_words(N_IN, N_OUT, N_PT, CFG_W);
  localparam int CNT_W     = (N_WORDS < 2) ? 1 : $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(N_WORDS - 1);

  cfg_state_e             r_state;
  logic [CNT_W-1:0]       r_word_cnt;
  logic [FUSE_BITS-1:0]   r_shadow;
  logic [FUSE_BITS-1:0]   r_active;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_loaded;

  logic                   w_accept;
  logic                   w_clr;
  logic [FUSE_BITS-1:0]   w_wr_en;
  logic [FUSE_BITS-1:0]   w_wr_data;
  logic [N_OUT-1:0]       w_q;
  logic [NL-1:0]          w_lit;
  logic [N_OUT*N_PT-1:0]  w_term;

  // A restart in the same cycle as a valid word discards that word.
  assign w_accept = (r_state == LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign w_clr    = (r_state == COMMIT);
  assign w_lit    = {w_q, bus.in_i};

  for (genvar i = 0; i < FUSE_BITS; i++) begin : g_shadow_wr
    localparam int C_WORD = i / CFG_W;
    assign w_wr_en[i]   = w_accept && (r_word_cnt == CNT_W'(C_WORD));
    assign w_wr_data[i] = bus.cfg_data[i % CFG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_shadow <= (r_shadow & ~w_wr_en) | (w_wr_data & w_wr_en);
      case (r_state)
        IDLE: begin
          if (bus.cfg_start) begin
            r_state    <= LOAD;
            r_word_cnt <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.cfg_start) begin
            r_word_cnt <= '0;
          end else if (bus.cfg_valid) begin
            if (r_word_cnt == C_LAST_WORD) begin
              r_state    <= COMMIT;
              r_word_cnt <= '0;
              r_ready    <= 1'b0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          r_active <= r_shadow;
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_loaded <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_mc
    localparam int C_MODE = f_mode_idx(o, N_IN, N_OUT, N_PT);

    for (genvar t = 0; t < N_PT; t++) begin : g_pt
      localparam int C_BASE = f_lit_idx(o, t, 0, N_IN, N_OUT, N_PT);
      logic [NL-1:0] w_ok;

      for (genvar l = 0; l < NL; l++) begin : g_lit
        localparam int C_IDX = f_lit_idx(o, t, l, N_IN, N_OUT, N_PT);
        assign w_ok[l] = (!r_active[C_IDX]     ||  w_lit[l]) &&
                         (!r_active[C_IDX + 1] || !w_lit[l]);
      end

      // An unprogrammed term must read as 0, not as an empty AND.
      assign w_term[o*N_PT + t] = (|r_active[C_BASE +: PT_BITS]) && (&w_ok);
    end

    pal_macrocell #(
      .N_PT (N_PT)
    ) u_mc (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_terms    (w_term[o*N_PT +: N_PT]),
      .i_reg_mode (r_active[C_MODE]),
      .i_invert   (r_active[C_MODE + 1]),
      .o_out      (bus.out_o[o]),
      .o_q        (w_q[o])
    );
  end

  assign bus.cfg_ready  = r_ready;
  assign bus.cfg_busy   = r_busy;
  assign bus.cfg_done   = r_done;
  assign bus.cfg_loaded = r_loaded;

endmodule

`default_nettype wire
